matvec8_driver: RTL and testbench
=================================

# matvec8_driver

Host-side initiator for the 8x8 matrix-vector multiplier: the block owns the other end of the multiplier's input_valid/input_ready/new_matrix and output_valid/output_ready handshakes. A host fills a local operand buffer (64 matrix words plus 8 vector words). On start, the block streams the operands into the multiplier and collects the 8 results into a readable result buffer. It sits between the system/testbench host and the multiplier top, one per multiplier instance.

## Interface
- N, 8, matrix dimension; fixed, not overridable
- IN_W, 14, signed operand width
- OUT_W, 28, signed result width
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; 0 = in reset
- wr_en  input  1  host operand write strobe
- wr_addr  input  7  0..63 = matrix (row-major, addr = row*8+col); 64..71 = vector element addr-64; 72..127 ignored
- wr_data  input  IN_W  signed operand
- start  input  1  one-cycle request to run one transaction
- send_matrix  input  1  sampled with start; 1 = resend matrix before vector
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse, all 8 results captured
- wr_err  output  1  sticky; a write arrived while busy
- rd_addr  input  3  result index
- rd_data  output  OUT_W  result[rd_addr], combinational read
- mv_input_valid  output  1  to multiplier input_valid
- mv_input_ready  input  1  from multiplier input_ready
- mv_input_data  output  IN_W  to multiplier input_data
- mv_new_matrix  output  1  to multiplier new_matrix
- mv_output_valid  input  1  from multiplier output_valid
- mv_output_ready  output  1  to multiplier output_ready
- mv_output_data  input  OUT_W  from multiplier output_data

## Operation
- States: IDLE, SEND_W, SEND_X, RECV.
- IDLE
  - start with send_matrix=1, or with no matrix sent since reset -> SEND_W.
  - Otherwise start -> SEND_X.
  - start clears wr_err.
- SEND_W
  - Word k = matrix[k], k=0..63.
  - mv_new_matrix=1 only with word 0; 0 otherwise.
  - After handshake of k=63 -> SEND_X; sets the internal matrix_loaded flag.
- SEND_X
  - Word j = vector[j], j=0..7, mv_new_matrix=0.
  - After handshake of j=7 -> RECV.
- RECV
  - mv_output_ready=1.
  - Each mv_output_valid&&mv_output_ready writes mv_output_data to result[idx] and increments idx.
  - After idx=7 captured -> IDLE, done=1 for that cycle.
- Handshake: a word transfers on a cycle with mv_input_valid && mv_input_ready. mv_input_valid/data/new_matrix hold stable until transfer. No bubbles when mv_input_ready stays high.
- start while busy: ignored.
- wr_en while busy: write dropped, wr_err set.
- Writes in IDLE, including same cycle as start: write takes effect and the transaction uses the new value.
- Out-of-range wr_addr: ignored, no error.
- mv_output_valid outside RECV: not accepted (ready=0), no capture.
- Result buffer keeps the previous transaction's values until overwritten per index.

## Timing
- Reset values
  - Outputs: busy=0, done=0, wr_err=0, mv_input_valid=0, mv_new_matrix=0, mv_output_ready=0.
  - mv_input_data=0; matrix_loaded=0; counters 0; state IDLE.
  - Operand and result buffers are not reset; rd_data is undefined until first capture.
- start at cycle t (IDLE): busy=1 and mv_input_valid=1 at t+1, first word presented at t+1.
- Full-matrix transaction with always-ready multiplier: 72 input transfers, cycles t+1..t+72. mv_output_ready rises at t+73.
- done asserts the cycle after the 8th output transfer; busy falls in the same cycle as done.
- Reset deasserted mid-transaction: everything returns to reset values asynchronously; no partial done. The next start forces a matrix send because matrix_loaded=0.
- Counters: 6-bit word counter, 3-bit vector and result index. They wrap only by state exit; no modular reuse.

## Structure
- Shared package matvec8_pkg
  - N, IN_W, OUT_W.
  - Address map constants: MAT_BASE=0, VEC_BASE=64, VEC_END=71.
  - State enum drv_state_t {IDLE, SEND_W, SEND_X, RECV}.
- One sub-module, matvec8_operand_buf
  - 72x14 write-port/read-port array.
  - Synchronous write, combinational read indexed by the driver's send pointer.
- FSM, counters, and result buffer live in matvec8_driver.

## Test plan
- Reset, load identity matrix and vector 1..8, start send_matrix=0 -> matrix forced: 64+8 transfers, mv_new_matrix=1 only on first; with ideal multiplier, results read back 1..8; done one pulse.
- Second start send_matrix=0 with vector -1..-8 -> exactly 8 transfers, mv_new_matrix never 1, results -1..-8.
- mv_input_ready toggling every other cycle -> data/valid held stable while ready=0; word order unchanged.
- mv_output_valid delayed 5 cycles per result and spurious valid during SEND_X -> only 8 captures, all in RECV.
- Write to addr 70 while busy -> wr_err=1, vector[6] unchanged; next start clears wr_err.
- Assert reset at word 30 of SEND_W -> all outputs to reset values immediately; next start resends full matrix.

Source files
------------

// File: rtl/matvec8_pkg.sv
// Shared constants, address map and FSM state type for the 8x8 matrix-vector driver.
package matvec8_pkg;

  localparam int N         = 8;
  localparam int IN_W      = 14;
  localparam int OUT_W     = 28;
  localparam int NUM_WORDS = N * N + N;

  localparam logic [6:0] MAT_BASE = 7'd0;
  localparam logic [6:0] VEC_BASE = 7'd64;
  localparam logic [6:0] VEC_END  = 7'd71;

  typedef enum logic [1:0] {
    IDLE,
    SEND_W,
    SEND_X,
    RECV
  } drv_state_t;

  // Addresses above the vector region are silently dropped by the buffer.
  function automatic logic is_operand_addr(input logic [6:0] addr);
    return addr <= VEC_END;
  endfunction

endpackage

// File: rtl/matvec8_operand_buf.sv
// 72-word operand store: 64 matrix words (row-major) followed by 8 vector words.
module matvec8_operand_buf
  import matvec8_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en,
  input  logic [6:0]      wr_addr,
  input  logic [IN_W-1:0] wr_data,
  input  logic [6:0]      rd_addr,
  output logic [IN_W-1:0] rd_data
);

  logic [IN_W-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en && is_operand_addr(wr_addr)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/matvec8_driver.sv
// Host-side initiator: streams buffered operands into the 8x8 multiplier and
// collects its 8 results into a readable result buffer.
module matvec8_driver
  import matvec8_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [6:0]              wr_addr,
  input  logic signed [IN_W-1:0]  wr_data,
  input  logic                    start,
  input  logic                    send_matrix,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_err,
  input  logic [2:0]              rd_addr,
  output logic signed [OUT_W-1:0] rd_data,
  output logic                    mv_input_valid,
  input  logic                    mv_input_ready,
  output logic signed [IN_W-1:0]  mv_input_data,
  output logic                    mv_new_matrix,
  input  logic                    mv_output_valid,
  output logic                    mv_output_ready,
  input  logic signed [OUT_W-1:0] mv_output_data
);

  drv_state_t state_q, state_d;
  logic [5:0] word_cnt_q, word_cnt_d;
  logic [2:0] vec_idx_q, vec_idx_d;
  logic [2:0] res_idx_q, res_idx_d;
  logic       matrix_loaded_q, matrix_loaded_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wr_err_q, wr_err_d;
  logic       in_valid_q, in_valid_d;
  logic       new_matrix_q, new_matrix_d;
  logic       out_ready_q, out_ready_d;

  logic [6:0]      send_ptr;
  logic [IN_W-1:0] buf_rd_data;
  logic            buf_wr_en;
  logic            in_fire;
  logic            out_fire;
  logic [OUT_W-1:0] result_q [N];

  // Operands are frozen while a transaction runs so the presented word stays stable.
  assign buf_wr_en = wr_en && !busy_q;
  assign send_ptr  = (state_q == SEND_W) ? (MAT_BASE + {1'b0, word_cnt_q})
                                         : (VEC_BASE + {4'b0, vec_idx_q});
  assign in_fire   = in_valid_q && mv_input_ready;
  assign out_fire  = out_ready_q && mv_output_valid;

  matvec8_operand_buf u_operand_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (send_ptr),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    vec_idx_d       = vec_idx_q;
    res_idx_d       = res_idx_q;
    matrix_loaded_d = matrix_loaded_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    wr_err_d        = wr_err_q;
    in_valid_d      = in_valid_q;
    new_matrix_d    = new_matrix_q;
    out_ready_d     = out_ready_q;

    if (wr_en && busy_q) begin
      wr_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_err_d   = 1'b0;
          busy_d     = 1'b1;
          in_valid_d = 1'b1;
          if (send_matrix || !matrix_loaded_q) begin
            state_d      = SEND_W;
            word_cnt_d   = 6'd0;
            new_matrix_d = 1'b1;
          end else begin
            state_d   = SEND_X;
            vec_idx_d = 3'd0;
          end
        end
      end
      SEND_W: begin
        if (in_fire) begin
          new_matrix_d = 1'b0;
          if (word_cnt_q == 6'(N * N - 1)) begin
            state_d         = SEND_X;
            word_cnt_d      = 6'd0;
            vec_idx_d       = 3'd0;
            matrix_loaded_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 6'd1;
          end
        end
      end
      SEND_X: begin
        if (in_fire) begin
          if (vec_idx_q == 3'(N - 1)) begin
            state_d     = RECV;
            vec_idx_d   = 3'd0;
            in_valid_d  = 1'b0;
            out_ready_d = 1'b1;
            res_idx_d   = 3'd0;
          end else begin
            vec_idx_d = vec_idx_q + 3'd1;
          end
        end
      end
      RECV: begin
        if (out_fire) begin
          if (res_idx_q == 3'(N - 1)) begin
            state_d     = IDLE;
            res_idx_d   = 3'd0;
            out_ready_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            res_idx_d = res_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      word_cnt_q      <= 6'd0;
      vec_idx_q       <= 3'd0;
      res_idx_q       <= 3'd0;
      matrix_loaded_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      wr_err_q        <= 1'b0;
      in_valid_q      <= 1'b0;
      new_matrix_q    <= 1'b0;
      out_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      vec_idx_q       <= vec_idx_d;
      res_idx_q       <= res_idx_d;
      matrix_loaded_q <= matrix_loaded_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      wr_err_q        <= wr_err_d;
      in_valid_q      <= in_valid_d;
      new_matrix_q    <= new_matrix_d;
      out_ready_q     <= out_ready_d;
    end
  end

  // Result storage is not reset; entries persist until the next capture at that index.
  always_ff @(posedge clk) begin
    if (out_fire) begin
      result_q[res_idx_q] <= mv_output_data;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign wr_err          = wr_err_q;
  assign mv_input_valid  = in_valid_q;
  assign mv_input_data   = in_valid_q ? buf_rd_data : '0;
  assign mv_new_matrix   = new_matrix_q;
  assign mv_output_ready = out_ready_q;
  assign rd_data         = result_q[rd_addr];

endmodule

// File: tb/tb_matvec8_driver.sv
// Self-checking bench for matvec8_driver with a behavioural 8x8 multiplier on the far side.
`timescale 1ns/1ps
module tb_matvec8_driver;
   import matvec8_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    wr_en = 1'b0;
   logic [6:0]              wr_addr = '0;
   logic signed [IN_W-1:0]  wr_data = '0;
   logic                    start = 1'b0;
   logic                    send_matrix = 1'b0;
   logic                    busy;
   logic                    done;
   logic                    wr_err;
   logic [2:0]              rd_addr = '0;
   logic signed [OUT_W-1:0] rd_data;
   logic                    mv_input_valid;
   logic                    mv_input_ready = 1'b1;
   logic signed [IN_W-1:0]  mv_input_data;
   logic                    mv_new_matrix;
   logic                    mv_output_valid = 1'b0;
   logic                    mv_output_ready;
   logic signed [OUT_W-1:0] mv_output_data = '0;

   typedef struct packed {
      logic [IN_W-1:0] data;
      logic            nm;
   } word_t;

   // Scoreboards filled by the host side when a transaction is launched
   word_t                   exp_words[$];
   logic signed [OUT_W-1:0] exp_res[$];

   // Host's view of what the operand buffer should contain
   logic signed [IN_W-1:0]  tb_mat [64];
   logic signed [IN_W-1:0]  tb_vec [8];
   bit                      tb_mat_loaded = 0;

   // Multiplier model state
   logic signed [IN_W-1:0]  m_mat [64];
   logic signed [IN_W-1:0]  m_vec [8];
   logic signed [OUT_W-1:0] mres_q[$];
   bit                      m_mat_mode = 0;
   int                      m_widx = 0;
   int                      m_vidx = 0;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  xfer_cnt = 0;
   int  nm_cnt = 0;
   int  cap_cnt = 0;
   int  done_cnt = 0;
   int  xfer_base, nm_base, cap_base, done_base;
   int  start_cyc = 0;
   int  last_done_cyc = 0;
   int  ready_rise_cyc = 0;
   bit  ready_prev = 0;
   bit  prev_stall = 0;
   logic [IN_W-1:0] prev_data;
   logic prev_nm;
   bit  out_fire = 0;
   bit  ready_mode = 0;
   int  out_delay = 0;
   bit  spurious_en = 0;
   bit  spur_active = 0;
   int  delay_cnt = 0;
   int  prev_size = 0;

   matvec8_driver dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .start           (start),
      .send_matrix     (send_matrix),
      .busy            (busy),
      .done            (done),
      .wr_err          (wr_err),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .mv_input_valid  (mv_input_valid),
      .mv_input_ready  (mv_input_ready),
      .mv_input_data   (mv_input_data),
      .mv_new_matrix   (mv_new_matrix),
      .mv_output_valid (mv_output_valid),
      .mv_output_ready (mv_output_ready),
      .mv_output_data  (mv_output_data)
   );

   // 100 MHz clock and a cycle counter used for latency checks
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Multiplier input_ready: always high, or high every other cycle in toggle mode
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode) mv_input_ready = ~mv_input_ready;
         else mv_input_ready = 1'b1;
      end
   end

   // Monitor at the falling edge: checks word order and stability, and models the multiplier's input side
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 0;
         ready_prev = 0;
         out_fire   = 0;
         mres_q.delete();
         m_mat_mode = 0;
         m_widx     = 0;
         m_vidx     = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (mv_input_valid !== 1'b1 || mv_input_data !== prev_data || mv_new_matrix !== prev_nm) begin
               failures++;
               $display("[TB] FAIL hold_stable: valid=%0b data=%0h nm=%0b, required valid=1 data=%0h nm=%0b",
                        mv_input_valid, mv_input_data, mv_new_matrix, prev_data, prev_nm);
            end
         end
         if (mv_input_valid) begin
            checks++;
            if (mv_output_ready !== 1'b0) begin
               failures++;
               $display("[TB] FAIL out_ready_while_sending: got %0b expected 0", mv_output_ready);
            end
         end
         if (mv_input_valid && mv_input_ready) begin
            word_t w;
            xfer_cnt++;
            if (mv_new_matrix) nm_cnt++;
            checks++;
            if (exp_words.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_word: got data=%0h nm=%0b, required no transfer", mv_input_data, mv_new_matrix);
            end else begin
               w = exp_words.pop_front();
               if (mv_input_data !== w.data || mv_new_matrix !== w.nm) begin
                  failures++;
                  $display("[TB] FAIL word_order: transfer %0d got data=%0h nm=%0b, required data=%0h nm=%0b",
                           xfer_cnt - 1, mv_input_data, mv_new_matrix, w.data, w.nm);
               end
            end
            if (mv_new_matrix) begin
               m_mat_mode = 1;
               m_widx     = 0;
            end
            if (m_mat_mode) begin
               m_mat[m_widx] = mv_input_data;
               m_widx++;
               if (m_widx == 64) m_mat_mode = 0;
            end else begin
               m_vec[m_vidx] = mv_input_data;
               m_vidx++;
               if (m_vidx == 8) begin
                  for (int i = 0; i < 8; i++) begin
                     longint sum;
                     sum = 0;
                     for (int j = 0; j < 8; j++) sum += longint'(m_mat[i*8+j]) * longint'(m_vec[j]);
                     mres_q.push_back(OUT_W'(sum));
                  end
                  m_vidx = 0;
               end
            end
         end
         out_fire = mv_output_valid && mv_output_ready;
         if (out_fire) cap_cnt++;
         if (done) done_cnt++;
         if (mv_output_ready && !ready_prev) ready_rise_cyc = cyc;
         ready_prev = mv_output_ready;
         prev_stall = mv_input_valid && !mv_input_ready;
         prev_data  = mv_input_data;
         prev_nm    = mv_new_matrix;
      end
   end

   // Multiplier output side: presents results with an optional per-result delay and spurious valids
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            mv_output_valid = 1'b0;
            spur_active     = 0;
            delay_cnt       = 0;
            prev_size       = 0;
         end else begin
            if (spur_active) begin
               mv_output_valid = 1'b0;
               spur_active     = 0;
            end else if (mv_output_valid && out_fire) begin
               void'(mres_q.pop_front());
               mv_output_valid = 1'b0;
               delay_cnt       = out_delay;
            end
            if (mres_q.size() > 0 && prev_size == 0) delay_cnt = out_delay;
            if (!mv_output_valid) begin
               if (mres_q.size() > 0) begin
                  if (delay_cnt > 0) delay_cnt--;
                  else begin
                     mv_output_valid = 1'b1;
                     mv_output_data  = mres_q[0];
                  end
               end else if (spurious_en && !m_mat_mode && m_vidx >= 1 && m_vidx <= 6) begin
                  mv_output_valid = 1'b1;
                  mv_output_data  = 28'sh5A5A5A5;
                  spur_active     = 1;
               end
            end
            prev_size = mres_q.size();
         end
      end
   end

   task automatic load_all();
      for (int k = 0; k < 72; k++) begin
         @(posedge clk);
         #1;
         wr_en   = 1'b1;
         wr_addr = 7'(k);
         wr_data = (k < 64) ? tb_mat[k] : tb_vec[k-64];
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   // Launches one transaction, optionally with a same-cycle operand write, and queues expectations
   task automatic issue_start(input bit send_m, input bit do_wr, input int addr, input int data);
      bit force_w;
      force_w = send_m || !tb_mat_loaded;
      if (do_wr) begin
         if (addr < 64) tb_mat[addr] = IN_W'(data);
         else if (addr < 72) tb_vec[addr-64] = IN_W'(data);
      end
      if (force_w) begin
         for (int k = 0; k < 64; k++) exp_words.push_back('{data: tb_mat[k], nm: (k == 0)});
      end
      for (int j = 0; j < 8; j++) exp_words.push_back('{data: tb_vec[j], nm: 1'b0});
      for (int i = 0; i < 8; i++) begin
         longint sum;
         sum = 0;
         for (int j = 0; j < 8; j++) sum += longint'(tb_mat[i*8+j]) * longint'(tb_vec[j]);
         exp_res.push_back(OUT_W'(sum));
      end
      @(posedge clk);
      #1;
      start       = 1'b1;
      send_matrix = send_m;
      if (do_wr) begin
         wr_en   = 1'b1;
         wr_addr = 7'(addr);
         wr_data = IN_W'(data);
      end
      start_cyc = cyc;
      xfer_base = xfer_cnt;
      nm_base   = nm_cnt;
      cap_base  = cap_cnt;
      done_base = done_cnt;
      @(posedge clk);
      #1;
      start       = 1'b0;
      send_matrix = 1'b0;
      wr_en       = 1'b0;
      checks++;
      if (busy !== 1'b1 || mv_input_valid !== 1'b1 || mv_new_matrix !== force_w || wr_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_response: busy=%0b valid=%0b nm=%0b wr_err=%0b, required 1 1 %0b 0",
                  busy, mv_input_valid, mv_new_matrix, wr_err, force_w);
      end
      if (force_w) tb_mat_loaded = 1;
   endtask

   // Waits (bounded) for done, then checks counts, pulse width and the result buffer
   task automatic wait_done(input int exp_xfers, input int exp_nm);
      bit seen;
      seen = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
      end
      last_done_cyc = cyc;
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL done_timeout: done not seen within 3000 cycles, required one pulse");
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL busy_at_done: got %0b expected 0", busy);
      end
      checks++;
      if (xfer_cnt - xfer_base !== exp_xfers) begin
         failures++;
         $display("[TB] FAIL xfer_count: got %0d expected %0d", xfer_cnt - xfer_base, exp_xfers);
      end
      checks++;
      if (nm_cnt - nm_base !== exp_nm) begin
         failures++;
         $display("[TB] FAIL new_matrix_count: got %0d expected %0d", nm_cnt - nm_base, exp_nm);
      end
      checks++;
      if (cap_cnt - cap_base !== 8) begin
         failures++;
         $display("[TB] FAIL capture_count: got %0d expected 8", cap_cnt - cap_base);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_pulse: cycle after done got done=%0b busy=%0b, required 0 0", done, busy);
      end
      checks++;
      if (exp_words.size() != 0) begin
         failures++;
         $display("[TB] FAIL words_left: got %0d unsent words, required 0", exp_words.size());
         exp_words.delete();
      end
      for (int i = 0; i < 8; i++) begin
         logic signed [OUT_W-1:0] exp;
         exp = (exp_res.size() > 0) ? exp_res.pop_front() : '0;
         rd_addr = 3'(i);
         #1;
         checks++;
         if (rd_data !== exp) begin
            failures++;
            $display("[TB] FAIL result[%0d]: got %0d expected %0d", i, rd_data, exp);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0 || mv_input_valid !== 1'b0 ||
          mv_new_matrix !== 1'b0 || mv_output_ready !== 1'b0 || mv_input_data !== '0) begin
         failures++;
         $display("[TB] FAIL %s: busy=%0b done=%0b wr_err=%0b valid=%0b nm=%0b out_ready=%0b data=%0h, required all 0",
                  tag, busy, done, wr_err, mv_input_valid, mv_new_matrix, mv_output_ready, mv_input_data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_values");
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("after_reset_release");
   endtask

   task automatic test_first_txn();
      for (int k = 0; k < 64; k++) tb_mat[k] = (k / 8 == k % 8) ? 14'sd1 : 14'sd0;
      for (int j = 0; j < 8; j++) tb_vec[j] = IN_W'(j + 1);
      load_all();
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_addr = 7'd100;
      wr_data = 14'sh1555;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      checks++;
      if (wr_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL out_of_range_write: wr_err got %0b expected 0", wr_err);
      end
      issue_start(1'b0, 1'b0, 0, 0);
      wait_done(72, 1);
      checks++;
      if (ready_rise_cyc - start_cyc !== 73) begin
         failures++;
         $display("[TB] FAIL out_ready_latency: got %0d expected 73", ready_rise_cyc - start_cyc);
      end
      checks++;
      if (last_done_cyc - start_cyc !== 81) begin
         failures++;
         $display("[TB] FAIL done_latency: got %0d expected 81", last_done_cyc - start_cyc);
      end
   endtask

   task automatic test_vector_only();
      for (int j = 0; j < 8; j++) tb_vec[j] = IN_W'(-(j + 1));
      load_all();
      issue_start(1'b0, 1'b1, 67, -44);
      wait_done(8, 0);
   endtask

   task automatic test_ready_toggle();
      for (int k = 0; k < 64; k++) tb_mat[k] = IN_W'(int'($urandom_range(0, 63)) - 32);
      for (int j = 0; j < 8; j++) tb_vec[j] = IN_W'(int'($urandom_range(0, 255)) - 128);
      load_all();
      ready_mode = 1;
      issue_start(1'b1, 1'b0, 0, 0);
      wait_done(72, 1);
      ready_mode = 0;
   endtask

   task automatic test_output_delay();
      for (int j = 0; j < 8; j++) tb_vec[j] = IN_W'(3 * j - 11);
      load_all();
      out_delay   = 5;
      spurious_en = 1;
      issue_start(1'b0, 1'b0, 0, 0);
      wait_done(8, 0);
      out_delay   = 0;
      spurious_en = 0;
   endtask

   task automatic test_wr_err();
      issue_start(1'b0, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_addr = 7'd70;
      wr_data = 14'sh0123;
      start   = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      start = 1'b0;
      checks++;
      if (wr_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wr_err_set: got %0b expected 1", wr_err);
      end
      wait_done(8, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done_cnt - done_base !== 1) begin
         failures++;
         $display("[TB] FAIL start_while_busy: busy=%0b done_pulses=%0d, required 0 and 1", busy, done_cnt - done_base);
      end
      checks++;
      if (wr_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wr_err_sticky: got %0b expected 1", wr_err);
      end
      issue_start(1'b0, 1'b0, 0, 0);
      wait_done(8, 0);
   endtask

   task automatic test_reset_mid();
      bit reached;
      reached = 0;
      issue_start(1'b1, 1'b0, 0, 0);
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (xfer_cnt - xfer_base >= 30) begin
            reached = 1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         failures++;
         $display("[TB] FAIL reach_word30: got %0d transfers, required 30", xfer_cnt - xfer_base);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset_mid");
      exp_words.delete();
      exp_res.delete();
      tb_mat_loaded = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("held_in_reset");
      checks++;
      if (done_cnt - done_base !== 0) begin
         failures++;
         $display("[TB] FAIL partial_done: got %0d pulses expected 0", done_cnt - done_base);
      end
      reset = 1'b1;
      issue_start(1'b0, 1'b0, 0, 0);
      wait_done(72, 1);
   endtask

   initial begin
      test_reset();
      test_first_txn();
      test_vector_only();
      test_ready_toggle();
      test_output_delay();
      test_wr_err();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
